// File: rtl/clock_timer_core.sv
// Time-of-day clock, background stopwatch and countdown with debounced keys and a SET mode.
// Define CLOCK_TIMER_CORE_ALARM_EN to add the alarm (set_field 6/7, alarm output).
module clock_timer_core #(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int HOUR_MODULO     = 24,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       KEY_MODE,
  input  logic       KEY_START,
  input  logic       KEY_CLEAR,
  input  logic       KEY_ADV,
  input  logic [6:0] set_value,
  input  logic       alarm_arm,
  output logic [1:0] mode,
  output logic [2:0] set_field,
  output logic [6:0] disp_hours,
  output logic [5:0] disp_minutes,
  output logic [5:0] disp_seconds,
  output logic       tick,
  output logic       sw_running,
  output logic       cd_running,
  output logic       expired,
  output logic       alarm
);

  typedef enum logic [1:0] {M_CLOCK, M_SW, M_CD, M_SET} mode_t;

  localparam int         PW   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int         DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [6:0] HMAX = 7'(HOUR_MODULO - 1);
`ifdef CLOCK_TIMER_CORE_ALARM_EN
  localparam logic [2:0] FIELD_MAX = 3'd7;
`else
  localparam logic [2:0] FIELD_MAX = 3'd5;
`endif

  function automatic logic [6:0] sat(input logic [6:0] v, input logic [6:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // ---------------- key conditioning: {adv, clear, start, mode} ----------------
  logic [3:0]    key_raw, sync1, sync2, level, level_d, press;
  logic [DW-1:0] db_cnt [4];

  assign key_raw = {KEY_ADV, KEY_CLEAR, KEY_START, KEY_MODE};

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: the per-key counter array is a handful of flops, not a RAM, so it is reset with the rest.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sync1   <= '1;
      sync2   <= '1;
      level   <= '1;
      level_d <= '1;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= key_raw;
      sync2   <= sync1;
      level_d <= level;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = level_d & ~level;

  // One action per cycle: MODE > CLEAR > START > ADV.
  logic act_mode, act_clear, act_start, act_adv;
  assign act_mode  = press[0];
  assign act_clear = press[2] & ~press[0];
  assign act_start = press[1] & ~press[0] & ~press[2];
  assign act_adv   = press[3] & ~|press[2:0];

  // ---------------- mode, field select, prescaler ----------------
  mode_t         mode_q;
  logic [PW-1:0] presc;
  logic          wr;

  assign wr   = act_start && (mode_q == M_SET);
  assign tick = (presc == PW'(CLK_FREQ - 1));

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      mode_q    <= M_CLOCK;
      set_field <= '0;
      presc     <= '0;
    end else begin
      if (act_mode) mode_q <= mode_t'(mode_q + 2'd1);
      if (act_adv && mode_q == M_SET)
        set_field <= (set_field == FIELD_MAX) ? 3'd0 : set_field + 3'd1;
      // Leaving SET restarts the second so the edited time begins on a full second.
      if ((act_mode && mode_q == M_SET) || tick) presc <= '0;
      else                                       presc <= presc + 1'b1;
    end
  end

  assign mode = mode_q;

  // ---------------- time of day ----------------
  logic [4:0] clk_h;
  logic [5:0] clk_m, clk_s;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      clk_h <= '0;
      clk_m <= '0;
      clk_s <= '0;
    end else if (wr && set_field <= 3'd2) begin
      case (set_field)
        3'd0:    clk_h <= 5'(sat(set_value, HMAX));
        3'd1:    clk_m <= 6'(sat(set_value, 7'd59));
        default: clk_s <= 6'(sat(set_value, 7'd59));
      endcase
    end else if (tick && mode_q != M_SET) begin
      if (clk_s == 6'd59) begin
        clk_s <= '0;
        if (clk_m == 6'd59) begin
          clk_m <= '0;
          clk_h <= (clk_h == HMAX[4:0]) ? 5'd0 : clk_h + 5'd1;
        end else begin
          clk_m <= clk_m + 6'd1;
        end
      end else begin
        clk_s <= clk_s + 6'd1;
      end
    end
  end

  // ---------------- stopwatch ----------------
  logic [6:0] sw_h;
  logic [5:0] sw_m, sw_s;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sw_h       <= '0;
      sw_m       <= '0;
      sw_s       <= '0;
      sw_running <= 1'b0;
    end else if (act_clear && mode_q == M_SW) begin
      sw_h       <= '0;
      sw_m       <= '0;
      sw_s       <= '0;
      sw_running <= 1'b0;
    end else begin
      if (act_start && mode_q == M_SW) sw_running <= ~sw_running;
      // Uses the pre-press run flag: a stop still takes this tick, a start waits for the next.
      if (tick && sw_running) begin
        if (sw_s == 6'd59) begin
          sw_s <= '0;
          if (sw_m == 6'd59) begin
            sw_m <= '0;
            sw_h <= (sw_h == 7'd99) ? 7'd0 : sw_h + 7'd1;
          end else begin
            sw_m <= sw_m + 6'd1;
          end
        end else begin
          sw_s <= sw_s + 6'd1;
        end
      end
    end
  end

  // ---------------- countdown preset and live count ----------------
  logic [6:0] pr_h, pr_h_n, cd_h;
  logic [5:0] pr_m, pr_m_n, pr_s, pr_s_n, cd_m, cd_s;
  logic       pr_wr, cd_zero, cd_last, cd_toggle;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pr_h_n = pr_h;
    pr_m_n = pr_m;
    pr_s_n = pr_s;
    if (wr) begin
      case (set_field)
        3'd3:    pr_h_n = sat(set_value, 7'd99);
        3'd4:    pr_m_n = 6'(sat(set_value, 7'd59));
        3'd5:    pr_s_n = 6'(sat(set_value, 7'd59));
        default: ;
      endcase
    end
  end

  assign pr_wr     = wr && (set_field >= 3'd3) && (set_field <= 3'd5);
  assign cd_zero   = (cd_h == 7'd0) && (cd_m == 6'd0) && (cd_s == 6'd0);
  assign cd_last   = (cd_h == 7'd0) && (cd_m == 6'd0) && (cd_s == 6'd1);
  assign cd_toggle = act_start && (mode_q == M_CD) && !cd_zero;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      pr_h       <= '0;
      pr_m       <= '0;
      pr_s       <= '0;
      cd_h       <= '0;
      cd_m       <= '0;
      cd_s       <= '0;
      cd_running <= 1'b0;
      expired    <= 1'b0;
    end else begin
      pr_h <= pr_h_n;
      pr_m <= pr_m_n;
      pr_s <= pr_s_n;
      if (act_clear && mode_q == M_CD) begin
        cd_h       <= pr_h;
        cd_m       <= pr_m;
        cd_s       <= pr_s;
        cd_running <= 1'b0;
        expired    <= 1'b0;
      end else if (pr_wr && !cd_running) begin
        cd_h <= pr_h_n;
        cd_m <= pr_m_n;
        cd_s <= pr_s_n;
      end else begin
        if (cd_toggle) cd_running <= ~cd_running;
        if (tick && cd_running) begin
          if (cd_s != 6'd0) begin
            cd_s <= cd_s - 6'd1;
          end else begin
            cd_s <= 6'd59;
            if (cd_m != 6'd0) begin
              cd_m <= cd_m - 6'd1;
            end else begin
              cd_m <= 6'd59;
              cd_h <= cd_h - 7'd1;
            end
          end
          // Reaching zero overrides any same-cycle START toggle.
          if (cd_last) begin
            expired    <= 1'b1;
            cd_running <= 1'b0;
          end
        end
      end
    end
  end

  // ---------------- alarm ----------------
`ifdef CLOCK_TIMER_CORE_ALARM_EN
  logic [4:0] al_h;
  logic [5:0] al_m;
  logic       tod_tick_d;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      al_h       <= '0;
      al_m       <= '0;
      tod_tick_d <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      tod_tick_d <= tick && (mode_q != M_SET);
      if (wr && set_field == 3'd6) al_h <= 5'(sat(set_value, HMAX));
      if (wr && set_field == 3'd7) al_m <= 6'(sat(set_value, 7'd59));
      // Only a real tick landing on hh:mm:00 fires, so a cleared alarm stays quiet for the minute.
      if (!alarm_arm || (act_clear && mode_q == M_CLOCK) || clk_m != al_m)
        alarm <= 1'b0;
      else if (tod_tick_d && clk_h == al_h && clk_s == 6'd0)
        alarm <= 1'b1;
    end
  end
`else
  logic unused_alarm_arm;
  assign unused_alarm_arm = alarm_arm;
  assign alarm            = 1'b0;
`endif

  // ---------------- display select ----------------
  logic [6:0] nx_h;
  logic [5:0] nx_m, nx_s;

  always_comb begin
    nx_h = '0;
    nx_m = '0;
    nx_s = '0;
    case (mode_q)
      M_CLOCK: begin nx_h = {2'b00, clk_h}; nx_m = clk_m; nx_s = clk_s; end
      M_SW:    begin nx_h = sw_h;           nx_m = sw_m;  nx_s = sw_s;  end
      M_CD:    begin nx_h = cd_h;           nx_m = cd_m;  nx_s = cd_s;  end
      default: begin
        if (set_field <= 3'd2) begin
          nx_h = {2'b00, clk_h}; nx_m = clk_m; nx_s = clk_s;
        end else if (set_field <= 3'd5) begin
          nx_h = pr_h; nx_m = pr_m; nx_s = pr_s;
        end
`ifdef CLOCK_TIMER_CORE_ALARM_EN
        else begin
          nx_h = {2'b00, al_h}; nx_m = al_m;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      disp_hours   <= '0;
      disp_minutes <= '0;
      disp_seconds <= '0;
    end else begin
      disp_hours   <= nx_h;
      disp_minutes <= nx_m;
      disp_seconds <= nx_s;
    end
  end

endmodule

// File: tb/tb_clock_timer_core.sv
// Directed bench for clock_timer_core (CLK_FREQ=10, DEBOUNCE_CYCLES=4); a second
// instance with HOUR_MODULO=12 shares all stimulus to cover the 12-hour rollover.
module tb_clock_timer_core;

  localparam int CLK_FREQ = 10;
  localparam int DEB      = 4;
  localparam int K_MODE = 0, K_START = 1, K_CLEAR = 2, K_ADV = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] keys;
  logic [6:0] set_value;
  logic       alarm_arm;

  logic [1:0] mode, mode12;
  logic [2:0] set_field, set_field12;
  logic [6:0] disp_hours, disp_hours12;
  logic [5:0] disp_minutes, disp_minutes12, disp_seconds, disp_seconds12;
  logic       tick, tick12, sw_running, sw_running12, cd_running, cd_running12;
  logic       expired, expired12, alarm, alarm12;

  int checks = 0;
  int failures = 0;
  int tick_cnt = 0;
  int snap;
  int n;

  clock_timer_core #(.CLK_FREQ(CLK_FREQ), .HOUR_MODULO(24), .DEBOUNCE_CYCLES(DEB)) dut (
    .CLOCK_50(clk), .RESET(rst),
    .KEY_MODE(keys[K_MODE]), .KEY_START(keys[K_START]),
    .KEY_CLEAR(keys[K_CLEAR]), .KEY_ADV(keys[K_ADV]),
    .set_value(set_value), .alarm_arm(alarm_arm),
    .mode(mode), .set_field(set_field),
    .disp_hours(disp_hours), .disp_minutes(disp_minutes), .disp_seconds(disp_seconds),
    .tick(tick), .sw_running(sw_running), .cd_running(cd_running),
    .expired(expired), .alarm(alarm)
  );

  clock_timer_core #(.CLK_FREQ(CLK_FREQ), .HOUR_MODULO(12), .DEBOUNCE_CYCLES(DEB)) dut12 (
    .CLOCK_50(clk), .RESET(rst),
    .KEY_MODE(keys[K_MODE]), .KEY_START(keys[K_START]),
    .KEY_CLEAR(keys[K_CLEAR]), .KEY_ADV(keys[K_ADV]),
    .set_value(set_value), .alarm_arm(alarm_arm),
    .mode(mode12), .set_field(set_field12),
    .disp_hours(disp_hours12), .disp_minutes(disp_minutes12), .disp_seconds(disp_seconds12),
    .tick(tick12), .sw_running(sw_running12), .cd_running(cd_running12),
    .expired(expired12), .alarm(alarm12)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tick) tick_cnt = tick_cnt + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic press_mask(input logic [3:0] m);
    @(posedge clk);
    #1;
    keys = keys & ~m;
    cyc(7);
    keys = '1;
    cyc(7);
  endtask

  task automatic press(input int k);
    press_mask(4'(1 << k));
  endtask

  task automatic wait_tick();
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!tick && w < 4 * CLK_FREQ);
    if (!tick) check("tick_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, "_h"}, disp_hours, h);
    check({tag, "_m"}, disp_minutes, m);
    check({tag, "_s"}, disp_seconds, s);
  endtask

  initial begin
    rst = 1'b1;
    keys = '1;
    set_value = '0;
    alarm_arm = 1'b0;
    cyc(3);
    @(negedge clk);
    check("reset_outputs", {mode, set_field, disp_hours, disp_minutes, disp_seconds,
                            tick, sw_running, cd_running, expired, alarm}, 0);
    rst = 1'b0;

    // Prescaler period
    wait_tick();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 4 * CLK_FREQ);
    check("tick_period", n, CLK_FREQ);

    // SET 23:59:59 (12-hour instance saturates to 11:59:59), then roll over
    repeat (3) press(K_MODE);
    @(negedge clk);
    check("set_mode", mode, 3);
    check("set_field0", set_field, 0);
    set_value = 7'd23;
    press(K_START);
    @(negedge clk);
    check("set_clk_h", disp_hours, 23);
    check("set_clk_h12_sat", disp_hours12, 11);
    press(K_ADV);
    set_value = 7'd75;
    press(K_START);
    @(negedge clk);
    check("set_clk_m_sat", disp_minutes, 59);
    press(K_ADV);
    set_value = 7'd59;
    press(K_START);
    @(negedge clk);
    check("set_clk_s", disp_seconds, 59);
    press(K_MODE);
    @(negedge clk);
    check("back_to_clock", mode, 0);
    wait_tick();
    @(negedge clk);
    check("disp_latency_old", disp_seconds, 59);
    @(negedge clk);
    check_time("roll24", 0, 0, 0);
    check("roll12_h", disp_hours12, 0);
    check("roll12_m", disp_minutes12, 0);
    check("roll12_s", disp_seconds12, 0);

    // Stopwatch keeps running while other modes are shown
    press(K_MODE);
    @(negedge clk);
    check("sw_mode", mode, 1);
    wait_tick();
    snap = tick_cnt;
    press(K_START);
    check("sw_started", sw_running, 1);
    repeat (3) press(K_MODE);
    @(negedge clk);
    check("sw_away", mode, 0);
    press(K_MODE);
    n = 0;
    while (tick_cnt - snap < 125 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("sw_tick_count", tick_cnt - snap, 125);
    @(negedge clk);
    @(negedge clk);
    check_time("sw_125", 0, 2, 5);
    check("sw_still_running", sw_running, 1);
    press(K_CLEAR);
    @(negedge clk);
    check_time("sw_clear", 0, 0, 0);
    check("sw_clear_stop", sw_running, 0);

    // Countdown preset 00:00:03 and expiry
    repeat (2) press(K_MODE);
    repeat (3) press(K_ADV);
    @(negedge clk);
    check("field_cd_s", set_field, 5);
    set_value = 7'd3;
    press(K_START);
    @(negedge clk);
    check("preset_s", disp_seconds, 3);
    repeat (3) press(K_MODE);
    @(negedge clk);
    check("cd_mode", mode, 2);
    check_time("cd_loaded", 0, 0, 3);
    wait_tick();
    snap = tick_cnt;
    press(K_START);
    check("cd_started", cd_running, 1);
    n = 0;
    while (cd_running && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("cd_ticks", tick_cnt - snap, 3);
    @(negedge clk);
    check_time("cd_zero", 0, 0, 0);
    check("cd_expired", expired, 1);
    check("cd_stopped", cd_running, 0);
    press(K_START);
    @(negedge clk);
    check("cd_start_at_zero", cd_running, 0);
    check("cd_still_zero", disp_seconds, 0);
    press(K_CLEAR);
    @(negedge clk);
    check_time("cd_reload", 0, 0, 3);
    check("cd_clear_expired", expired, 0);

    // MODE beats START in the same cycle: no write to cd_s
    press(K_MODE);
    set_value = 7'd50;
    press_mask(4'b0011);
    @(negedge clk);
    check("prio_mode", mode, 0);
    repeat (2) press(K_MODE);
    @(negedge clk);
    check("prio_mode2", mode, 2);
    check("prio_no_write", disp_seconds, 3);

    // Debounce: short glitch ignored, 6-cycle press gives exactly one event
    @(posedge clk);
    #1;
    keys[K_MODE] = 1'b0;
    cyc(3);
    keys = '1;
    cyc(10);
    @(negedge clk);
    check("glitch_ignored", mode, 2);
    keys[K_MODE] = 1'b0;
    cyc(6);
    keys = '1;
    cyc(10);
    @(negedge clk);
    check("press_once", mode, 3);

`ifdef CLOCK_TIMER_CORE_ALARM_EN
    press(K_ADV);
    @(negedge clk);
    check("field_al_h", set_field, 6);
    set_value = 7'd7;
    press(K_START);
    @(negedge clk);
    check("al_h_disp", disp_hours, 7);
    press(K_ADV);
    set_value = 7'd30;
    press(K_START);
    @(negedge clk);
    check("al_m_disp", disp_minutes, 30);
    press(K_ADV);
    @(negedge clk);
    check("field_wrap7", set_field, 0);
    set_value = 7'd7;
    press(K_START);
    press(K_ADV);
    set_value = 7'd29;
    press(K_START);
    press(K_ADV);
    set_value = 7'd59;
    press(K_START);
    alarm_arm = 1'b1;
    press(K_MODE);
    wait_tick();
    @(negedge clk);
    check("alarm_not_yet", alarm, 0);
    @(negedge clk);
    check("alarm_fires", alarm, 1);
    check_time("alarm_time", 7, 30, 0);
    press(K_CLEAR);
    @(negedge clk);
    check("alarm_cleared", alarm, 0);
    alarm_arm = 1'b0;
`else
    press(K_ADV);
    @(negedge clk);
    check("field_wrap5", set_field, 0);
    press(K_MODE);
    @(negedge clk);
    check("alarm_tied", alarm, 0);
`endif

    // RESET in the middle of a running countdown
    repeat (2) press(K_MODE);
    press(K_START);
    @(negedge clk);
    check("pre_reset_running", cd_running, 1);
    rst = 1'b1;
    #1;
    check("reset_async", {mode, set_field, disp_hours, disp_minutes, disp_seconds,
                          tick, sw_running, cd_running, expired, alarm}, 0);
    @(negedge clk);
    check("reset_next_cycle", {mode, set_field, disp_hours, disp_minutes, disp_seconds,
                               tick, sw_running, cd_running, expired, alarm}, 0);
    check("reset_dut12", {mode12, set_field12, disp_hours12, disp_minutes12, disp_seconds12,
                          tick12, sw_running12, cd_running12, expired12, alarm12}, 0);
    rst = 1'b0;
    cyc(2);
    @(negedge clk);
    check_time("after_reset", 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_timer_core.md
# clock_timer_core

Parametrised timekeeping core for the DE2 front panel: a time-of-day clock, a stopwatch and a countdown timer that all keep running in the background, plus a field-addressed SET mode. Raw KEY inputs are debounced and edge-detected internally. The block drives registered display fields; seven-segment, LED and LCD drivers sit downstream.

## Interface
- CLK_FREQ, 50_000_000: CLOCK_50 cycles per second tick; must be ≥ 2.
- HOUR_MODULO, 24: clock hours count 0..HOUR_MODULO-1; legal range 2..32.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a key level; must be ≥ 1.

Ports:
- CLOCK_50  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- KEY_MODE, KEY_START, KEY_CLEAR, KEY_ADV  in  1 each  raw active-low pushbuttons, asynchronous to CLOCK_50.
- set_value  in  7  value written by a SET-mode write.
- alarm_arm  in  1  alarm enable level; used only with CLOCK_TIMER_CORE_ALARM_EN.
- mode  out  2  0 CLOCK, 1 STOPWATCH, 2 COUNTDOWN, 3 SET.
- set_field  out  3  field selected in SET mode.
- disp_hours  out  7, disp_minutes  out  6, disp_seconds  out  6  binary fields for the current view.
- tick  out  1  one-cycle pulse per second.
- sw_running, cd_running  out  1 each  stopwatch and countdown run flags.
- expired  out  1  sticky countdown-done flag.
- alarm  out  1  alarm active.

## Operation
- **Key inputs:** each key passes through a 2-flop synchroniser, then a per-key stability counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - A debounced 1→0 transition produces a one-cycle press event.
- **Priority:** one action per cycle, in the order MODE > CLEAR > START > ADV. Lower-priority events in the same cycle are dropped.
- **MODE press:** mode goes 0→1→2→3→0. It is always accepted; the stopwatch and countdown keep running in every mode.
- **Prescaler:** counts 0..CLK_FREQ-1; tick is asserted in the cycle the count equals CLK_FREQ-1.
- **CLOCK time-of-day:** advances on tick in modes 0–2.
  - Seconds roll 59→0 and carry into minutes; minutes roll 59→0 and carry into hours; hours roll HOUR_MODULO-1→0.
  - In SET mode the time-of-day is frozen. Leaving SET clears the prescaler to 0.
- **STOPWATCH:**
  - START toggles sw_running; CLEAR zeroes it and stops it. Both act only while mode==1.
  - Counts up on tick while running, h:m:s, with hours wrapping 99→0.
- **COUNTDOWN:**
  - START toggles cd_running; a START with the count at 00:00:00 is ignored.
  - CLEAR reloads the preset, stops the count and clears expired. START and CLEAR act only while mode==2.
  - Decrements on tick while running, with borrows through seconds and minutes.
  - The transition to 00:00:00 sets expired and clears cd_running in the same cycle.
- **SET:**
  - ADV steps set_field through 0 clk_h, 1 clk_m, 2 clk_s, 3 cd_h, 4 cd_m, 5 cd_s, then wraps to 0.
  - START writes set_value into the selected field, saturating to the field maximum (hours HOUR_MODULO-1 or 99, minutes/seconds 59).
  - A write to a countdown field also reloads the live count when cd_running is 0.
- **Display select:** mode 0 shows the clock, 1 the stopwatch, 2 the countdown. Mode 3 shows clock fields for set_field 0–2, preset fields for 3–5, and alarm fields for 6–7.
- **Reset:**
  - Clears every counter, preset, flag, mode, set_field and debounce state.
  - Debounced key levels reset to 1 (released).
  - All outputs read 0, and RESET mid-count aborts immediately.

## Timing
- tick high in cycle N → counters hold the new value in N+1 → disp_* in N+2.
- Press event to state change: 1 cycle; to disp_*: 2 cycles.
- Raw key edge to press event: 2 + DEBOUNCE_CYCLES cycles. Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Tick and key action in the same cycle:
  - CLEAR wins over the increment or decrement, so the result is the cleared value.
  - START begins counting at the next tick.
  - A STOP press in the same cycle as a tick still applies that tick's update.

## Configuration
- **CLOCK_TIMER_CORE_ALARM_EN defined:**
  - set_field spans 0..7; 6 is alarm hour, 7 is alarm minute; both reset to 0.
  - alarm rises one cycle after the clock reaches hh:mm:00 equal to the alarm setting while alarm_arm=1.
  - alarm holds until the minute changes, alarm_arm=0, or CLEAR is pressed in mode 0.
- **Undefined:** set_field wraps 5→0, alarm is tied 0, alarm_arm is ignored, and no alarm registers exist.

## Test plan
Bench parameters: CLK_FREQ=10, DEBOUNCE_CYCLES=4.
- **Clock rollover:** set clock to 23:59:59 via SET, return to mode 0, wait one tick → disp 00:00:00. Repeat with HOUR_MODULO=12 from 11:59:59 → 00:00:00.
- **Background stopwatch:** start in mode 1, MODE to 0, wait 125 ticks, MODE ×1 back to mode 1 → 00:02:05 with sw_running=1. CLEAR → 00:00:00 with sw_running=0.
- **Countdown expiry:** preset 00:00:03, START in mode 2 → 00:00:00 after 3 ticks, expired=1, cd_running=0. A further START is ignored. CLEAR → 00:00:03 with expired=0.
- **SET saturation and priority:** set_value=75 written to clk_m → 59. MODE and START pulses in the same cycle → mode advances and no write occurs.
- **Debounce and reset:** a 3-cycle low glitch → no event. A 6-cycle press → exactly one event. RESET asserted mid-countdown → every output is 0 in the next cycle.
- **Alarm (macro defined):** alarm 07:30 with alarm_arm=1, clock 07:29:59 → alarm=1 after the tick. CLEAR in mode 0 → alarm=0.
